// File: rtl/debug_pkg.sv
// debug_pkg: state encoding and timing defaults shared by the debug UART transmit and receive sides.
package debug_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/baud_gen.sv
// baud_gen: bit-time counter that emits a one-cycle bit_done pulse every CLKS_PER_BIT cycles.
module baud_gen import debug_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    bit_done = !clear && cnt_q == LAST;
    cnt_d = (clear || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/debug_tx.sv
// debug_tx: sends a 32-bit debug word over a UART line as NUM_BYTES 8N1 bytes, most significant byte first.
module debug_tx import debug_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NUM_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);
  localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  localparam int IW = $clog2(BITS_PER_BYTE);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(BITS_PER_BYTE - 1);
  state_t state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0] cur_byte;
  logic accept, bit_done;
  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .bit_done(bit_done)
  );
  always_comb begin
    word_ready = state_q == IDLE;
    busy = !word_ready;
    accept = word_ready && word_valid;
    cur_byte = word_q[31:24];
    tx = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
  end
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    bit_d = bit_q;
    byte_d = byte_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        word_d = word_data;
        bit_d = '0;
        byte_d = '0;
      end
      START: if (bit_done) state_d = DATA;
      DATA: if (bit_done) begin
        state_d = bit_q == LAST_BIT ? STOP : DATA;
        bit_d = bit_q == LAST_BIT ? '0 : bit_q + IW'(1);
      end
      default: if (bit_done) begin
        // the next byte moves into the top lane so tx always reads word_q[31:24]
        state_d = byte_q == LAST_BYTE ? IDLE : START;
        byte_d = byte_q == LAST_BYTE ? '0 : byte_q + BW'(1);
        word_d = word_q << 8;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      word_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
    end
endmodule

// File: tb/tb_debug_tx.sv
// tb_debug_tx: directed checks of debug_tx framing, latching, back-to-back timing and reset behaviour.
module tb_debug_tx;
  logic clk, rst;
  logic [31:0] word_data;
  logic valid4, valid1;
  logic rdy4, tx4, busy4, rdy1, tx1, busy1;
  int checks = 0, errors = 0;

  debug_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(4)) dut4 (
    .clk(clk), .reset(rst), .word_data(word_data), .word_valid(valid4),
    .word_ready(rdy4), .tx(tx4), .busy(busy4)
  );
  debug_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(1)) dut1 (
    .clk(clk), .reset(rst), .word_data(word_data), .word_valid(valid1),
    .word_ready(rdy1), .tx(tx1), .busy(busy1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic send(input bit sel, input logic [31:0] d);
    word_data = d;
    if (sel) valid1 = 1; else valid4 = 1;
    @(posedge clk);
    #1;
    valid1 = 0;
    valid4 = 0;
  endtask

  // Samples every cycle of nb frames starting just after the accept edge.
  task automatic capture(input bit sel, input int nb, output logic [31:0] data,
                         output logic frame_ok, output logic ready_low);
    logic s, first;
    data = '0;
    frame_ok = 1;
    ready_low = 1;
    first = 0;
    for (int i = 0; i < nb; i++)
      for (int p = 0; p < 10; p++) begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          s = sel ? tx1 : tx4;
          if ((sel ? rdy1 : rdy4) !== 1'b0) ready_low = 0;
          if (c == 0) first = s;
          else if (s !== first) frame_ok = 0;
        end
        if (p == 0 && first !== 1'b0) frame_ok = 0;
        if (p == 9 && first !== 1'b1) frame_ok = 0;
        if (p >= 1 && p <= 8) data[24 - 8*i + p - 1] = first;
      end
  endtask

  task automatic test_reset;
    rst = 1;
    #2;
    checks++; if (tx4 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx4); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
    checks++; if (tx1 !== 1'b1 || rdy1 !== 1'b1) begin errors++; $display("FAIL reset_nb1 got tx=%b rdy=%b want 1 1", tx1, rdy1); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_single;
    logic [31:0] d;
    logic f, r;
    send(0, 32'hA5C3_0F81);
    capture(0, 4, d, f, r);
    checks++; if (d !== 32'hA5C3_0F81) begin errors++; $display("FAIL single_data got %h want a5c30f81", d); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL single_frame got %b want 1", f); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL single_ready_low got %b want 1", r); end
    @(negedge clk);
    checks++; if (rdy4 !== 1'b1 || tx4 !== 1'b1) begin errors++; $display("FAIL single_ready_161 got rdy=%b tx=%b want 1 1", rdy4, tx4); end
    @(posedge clk); #1;
  endtask

  task automatic test_stability;
    logic [31:0] d;
    logic f, r;
    send(0, 32'h1234_5678);
    fork
      capture(0, 4, d, f, r);
      repeat (160) begin @(posedge clk); #1 word_data = $urandom; end
    join
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL stable_data got %h want 12345678", d); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL stable_frame got %b want 1", f); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic f, r;
    word_data = 32'h0000_00FF;
    valid4 = 1;
    @(posedge clk);
    #1 word_data = 32'hFFFF_FF00;
    capture(0, 4, d, f, r);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL b2b_first got %h want 000000ff", d); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL b2b_first_frame got %b want 1", f); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL b2b_accept_while_busy ready_low=%b want 1", r); end
    @(negedge clk);
    checks++; if (tx4 !== 1'b1 || rdy4 !== 1'b1) begin errors++; $display("FAIL b2b_gap got tx=%b rdy=%b want 1 1", tx4, rdy4); end
    @(posedge clk);
    #1 valid4 = 0;
    capture(0, 4, d, f, r);
    checks++; if (d !== 32'hFFFF_FF00) begin errors++; $display("FAIL b2b_second got %h want ffffff00", d); end
    checks++; if (f !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL b2b_second_frame got frame=%b ready_low=%b want 1 1", f, r); end
    @(negedge clk);
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL b2b_end_ready got %b want 1", rdy4); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic f, r;
    send(0, 32'h0000_0000);
    repeat (98) @(negedge clk);
    checks++; if (tx4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL mid_before got tx=%b busy=%b want 0 1", tx4, busy4); end
    #1 rst = 1;
    #1;
    checks++; if (tx4 !== 1'b1 || rdy4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL mid_async got tx=%b rdy=%b busy=%b want 1 1 0", tx4, rdy4, busy4); end
    @(posedge clk);
    #1 rst = 0;
    send(0, 32'h0000_0001);
    capture(0, 4, d, f, r);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL mid_resend got %h want 00000001", d); end
    checks++; if (f !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL mid_resend_frame got frame=%b ready_low=%b want 1 1", f, r); end
    @(posedge clk); #1;
  endtask

  task automatic test_nb1;
    logic [31:0] d;
    logic f, r;
    send(1, 32'hDEAD_BEEF);
    capture(1, 1, d, f, r);
    checks++; if (d[31:24] !== 8'hDE) begin errors++; $display("FAIL nb1_byte got %h want de", d[31:24]); end
    checks++; if (f !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL nb1_frame got frame=%b ready_low=%b want 1 1", f, r); end
    @(negedge clk);
    checks++; if (rdy1 !== 1'b1 || tx1 !== 1'b1) begin errors++; $display("FAIL nb1_len got rdy=%b tx=%b want 1 1", rdy1, tx1); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle;
    logic tx_ok, busy_ok;
    tx_ok = 1;
    busy_ok = 1;
    repeat (100) begin
      @(negedge clk);
      word_data = $urandom;
      if (tx4 !== 1'b1 || tx1 !== 1'b1) tx_ok = 0;
      if (busy4 !== 1'b0 || busy1 !== 1'b0) busy_ok = 0;
    end
    checks++; if (tx_ok !== 1'b1) begin errors++; $display("FAIL idle_tx got %b want 1", tx_ok); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL idle_busy got %b want 1", busy_ok); end
  endtask

  initial begin
    valid4 = 0;
    valid1 = 0;
    word_data = '0;
    test_reset;
    test_single;
    test_stability;
    test_back_to_back;
    test_reset_mid;
    test_nb1;
    test_idle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_tx.md
DEBUG_TX -- requirements
Module: debug_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter NUM_BYTES, default 4, giving the bytes sent per accepted word (legal 1..4).
REQ-003 clk  input  1  single system clock; all state rises on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 word_data  input  32  word to transmit (PC, register or memory value from the datapath).
REQ-006 word_valid  input  1  word_data is offered this cycle.
REQ-007 word_ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  UART serial line, idle high.
REQ-009 busy  output  1  a word transfer is in progress.

Function
REQ-010 The block SHALL accept a word only in the cycle where word_valid and word_ready are both 1; it SHALL ignore word_valid at all other times.
REQ-011 word_ready SHALL be 1 only in state IDLE; busy SHALL be its inverse.
REQ-012 On accept, the block SHALL latch word_data internally, so later changes to word_data have no effect on the transfer.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if bytes remain, otherwise STOP -> IDLE, each after CLKS_PER_BIT cycles.
REQ-014 tx SHALL be 0 in START, the current data bit in DATA, and 1 in STOP and IDLE.
REQ-015 tx SHALL drop to 0 in the first cycle after the accept edge, giving a latency of 1 cycle.
REQ-016 Bytes SHALL be sent most-significant first: word_data[31:24], then [23:16], and so on. With NUM_BYTES<4 only the top NUM_BYTES bytes are sent.
REQ-017 Within a byte, bits SHALL be sent LSB first, in 8N1 format.
REQ-018 Each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-019 There SHALL be no idle gap between a STOP bit and the next START bit within one word.
REQ-020 A full transfer SHALL occupy exactly NUM_BYTES*10*CLKS_PER_BIT cycles.
REQ-021 word_ready SHALL rise in the first cycle after the last STOP bit completes, so a back-to-back accept gives minimum 1 idle-high cycle between words.
REQ-022 The bit-time counter SHALL count from 0 to CLKS_PER_BIT-1 and wrap to 0.
REQ-023 The bit-time counter SHALL be cleared on accept, so bit timing is aligned to the accept edge.
REQ-024 The bit index (0..7) and the byte index (0..NUM_BYTES-1) SHALL wrap without overflow, and each SHALL be sized with $clog2.

Reset
REQ-025 While reset is high, the block SHALL hold: state=IDLE, tx=1, word_ready=1, busy=0, and all counters and the latched word at 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer immediately and asynchronously, with tx=1 and no partial byte resumed.
REQ-027 After reset deasserts, the first accept SHALL be possible on the first clk edge.

Structure
REQ-028 The state encoding constants and the default CLKS_PER_BIT SHALL reside in a shared package, debug_pkg, for reuse by the receive side.
REQ-029 Bit timing SHALL be implemented in one sub-module, baud_gen. It takes clk, reset and a clear input, and outputs a 1-cycle bit_done pulse.
REQ-030 The remaining state SHALL be in debug_tx: the FSM, the shift register and the byte/bit counters.

Verification (CLKS_PER_BIT=4, NUM_BYTES=4 unless noted)
REQ-031 Single word:
  - Stimulus: word_data=0xA5C3_0F81, valid for 1 cycle.
  - Required: tx shows bytes A5, C3, 0F, 81 in 8N1.
  - Required: word_ready low for exactly 160 cycles.
REQ-032 Data stability:
  - Stimulus: word_data changes every cycle during a transfer of 0x1234_5678.
  - Required: the serial stream is 12, 34, 56, 78.
REQ-033 Back-to-back:
  - Stimulus: valid held high with 0x0000_00FF then 0xFFFF_FF00.
  - Required: two frames separated by exactly 1 idle-high cycle.
  - Required: no accept while busy.
REQ-034 Reset mid-frame:
  - Stimulus: reset asserted during bit 3 of byte 2.
  - Required: tx=1 and word_ready=1 in the same cycle, with no clock edge needed.
  - Stimulus: word 0x0000_0001 sent next.
  - Required: it transmits correctly.
REQ-035 NUM_BYTES=1:
  - Stimulus: 0xDEAD_BEEF.
  - Required: a single byte DE is sent, and the transfer lasts 40 cycles.
REQ-036 Idle guard:
  - Stimulus: valid=0 for 100 cycles.
  - Required: tx stays 1 and busy stays 0 throughout.
